booth_mult_seq_param: RTL

//  Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 8-bit unit.

---
 rtl/booth_mult_seq_param_pkg.sv | 22 ++
 rtl/booth_mult_seq_param_if.sv | 31 +++
 rtl/booth_mult_seq_param_counter.sv | 34 +++
 rtl/booth_mult_seq_param.sv | 130 +++++++++++++
 4 files changed

// File: rtl/booth_mult_seq_param_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// mult_pkg: shared FSM encoding and Booth recoding constants for the sequential multiplier.
// Rev 1.0
package mult_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_RUN  = S_RUN,
      ST_DONE = S_DONE
   } state_t;

   // {Q[0], q_minus_1} patterns that select an add or a subtract of M
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage
`default_nettype wire

// File: rtl/booth_mult_seq_param_if.sv
`default_nettype none
`timescale 1ns/1ps
// booth_mult_seq_param_if: operand/result handshake bundle of the Booth multiplier.
// Rev 1.0
interface booth_mult_seq_param_if #(
   parameter int WIDTH = 8
);
   import mult_pkg::*;

   logic                 in_valid;
   logic                 in_ready;
   logic                 is_signed;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, is_signed, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, is_signed, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface
`default_nettype wire

// File: rtl/booth_mult_seq_param_counter.sv
`default_nettype none
`timescale 1ns/1ps
// counter_param: loadable down-counter; zero_flag marks the decrement that reaches zero.
// Rev 1.0
module counter_param
   import mult_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero_flag
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   // Flags the edge on which the count lands on zero, so the FSM leaves RUN on that same edge
   assign zero_flag = dec && (count == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq_param.sv
`default_nettype none
`timescale 1ns/1ps
// booth_mult_seq_param: sequential radix-2 Booth multiplier, signed/unsigned per operation.
// Rev 1.0
module booth_mult_seq_param
   import mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                   clk,
   input  logic                   rst,
   booth_mult_seq_param_if.slave  bus
);

   localparam int AW = WIDTH + 1;

   state_t          state;
   state_t          state_nx;

   logic [AW-1:0]   a_r;
   logic [AW-1:0]   m_r;
   logic [AW-1:0]   q_r;
   logic            qm1_r;

   logic            in_ready;
   logic            out_valid;
   logic            busy;
   logic            accept;
   logic            cnt_dec;
   logic            cnt_zero;

   logic [AW-1:0]   m_ext;
   logic [AW-1:0]   q_ext;
   logic [1:0]      booth_bits;
   logic            do_sub;
   logic            use_m;
   logic [AW-1:0]   addend;
   logic [AW-1:0]   sum;

   assign accept = bus.in_valid && in_ready;

   // An extra top bit (sign or zero) lets one signed datapath cover both modes
   assign m_ext = {bus.is_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
   assign q_ext = {bus.is_signed & bus.multiplier[WIDTH-1],   bus.multiplier};

   assign booth_bits = {q_r[0], qm1_r};
   assign do_sub     = (booth_bits == BOOTH_SUB);
   assign use_m      = (booth_bits == BOOTH_ADD) || do_sub;
   assign addend     = use_m ? (do_sub ? ~m_r : m_r) : '0;
   assign sum        = a_r + addend + {{(AW-1){1'b0}}, do_sub};

   counter_param #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .load      (accept),
      .load_val  (CNT_W'(WIDTH + 1)),
      .dec       (cnt_dec),
      .zero_flag (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      cnt_dec   = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            busy    = 1'b1;
            cnt_dec = 1'b1;
            if (cnt_zero) begin
               state_nx = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            in_ready  = bus.out_ready;
            if (bus.out_ready) begin
               state_nx = bus.in_valid ? ST_RUN : ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Add/sub and the arithmetic right shift of {A,Q,q_minus_1} happen on one edge
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         m_r   <= '0;
         q_r   <= '0;
         qm1_r <= 1'b0;
      end else if (accept) begin
         a_r   <= '0;
         m_r   <= m_ext;
         q_r   <= q_ext;
         qm1_r <= 1'b0;
      end else if (state == ST_RUN) begin
         a_r   <= {sum[AW-1], sum[AW-1:1]};
         q_r   <= {sum[0], q_r[AW-1:1]};
         qm1_r <= q_r[0];
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.busy      = busy;
   assign bus.product   = {a_r[WIDTH-2:0], q_r};

endmodule
`default_nettype wire
